// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad emulator.
// Holds the FSM state enum, the key code type and the LFSR seed/taps.
package keypad_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BNC_DN = 3'd1,
    HELD   = 3'd2,
    BNC_UP = 3'd3,
    GAP    = 3'd4
  } keypad_emu_state_t;

  typedef logic [3:0] key_code_t;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // x^8 + x^6 + x^5 + x^4 + 1
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/keypad_lfsr.sv
// keypad_lfsr: 8-bit Fibonacci LFSR used as the contact-bounce source.
// Ports: clk, reset (async, active-low), en (advance), state (8-bit).
module keypad_lfsr (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [7:0] state
);
  import keypad_pkg::*;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= LFSR_SEED;
    end else if (en) begin
      state <= {state[6:0], ^(state & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator: switch-matrix end of a 4x4 active-low keypad scan.
// Ports: clk, reset (async, active-low), cols in / rows out (active-low),
//   cmd_valid/cmd_ready/cmd_key/cmd_hold command port, busy, done pulse.
// Build option: define KEYPAD_EMU_BOUNCE_EN for press/release bounce.
module keypad_emulator #(
  parameter int BOUNCE_CYCLES = 16,
  parameter int GAP_CYCLES    = 32,
  parameter int HOLD_W        = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        cols,
  output logic [3:0]        rows,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_key,
  input  logic [HOLD_W-1:0] cmd_hold,
  output logic              busy,
  output logic              done
);
  import keypad_pkg::*;

  localparam int CW = imax(HOLD_W,
    imax($clog2(BOUNCE_CYCLES), $clog2(GAP_CYCLES)));

  keypad_emu_state_t state;
  logic [CW-1:0]     count;
  key_code_t         key;
  logic [HOLD_W-1:0] hold_in;
  logic              accept;
  logic              cnt_zero;
  logic              contact;

  assign cmd_ready = (state == IDLE);
  assign busy      = ~cmd_ready;
  assign accept    = cmd_valid & cmd_ready;
  assign cnt_zero  = (count == '0);
  assign done      = (state == GAP) & cnt_zero;
  // hold of 0 behaves as 1; counter holds hold-1
  assign hold_in   = (cmd_hold == '0) ? '0 : cmd_hold - 1'b1;

`ifdef KEYPAD_EMU_BOUNCE_EN
  logic [7:0]        lfsr;
  logic              lfsr_en;
  logic              lfsr_unused;
  logic [HOLD_W-1:0] hold_m1;

  assign lfsr_en     = (state == BNC_DN) | (state == BNC_UP);
  assign lfsr_unused = ^lfsr[7:1];

  keypad_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (lfsr_en),
    .state (lfsr)
  );
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      count   <= '0;
      key     <= '0;
`ifdef KEYPAD_EMU_BOUNCE_EN
      hold_m1 <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            key <= cmd_key;
`ifdef KEYPAD_EMU_BOUNCE_EN
            hold_m1 <= hold_in;
            state   <= BNC_DN;
            count   <= CW'(BOUNCE_CYCLES - 1);
`else
            state   <= HELD;
            count   <= CW'(hold_in);
`endif
          end
        end
`ifdef KEYPAD_EMU_BOUNCE_EN
        BNC_DN: begin
          if (cnt_zero) begin
            state <= HELD;
            count <= CW'(hold_m1);
          end else begin
            count <= count - 1'b1;
          end
        end
        BNC_UP: begin
          if (cnt_zero) begin
            state <= GAP;
            count <= CW'(GAP_CYCLES - 1);
          end else begin
            count <= count - 1'b1;
          end
        end
`endif
        HELD: begin
          if (cnt_zero) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
            state <= BNC_UP;
            count <= CW'(BOUNCE_CYCLES - 1);
`else
            state <= GAP;
            count <= CW'(GAP_CYCLES - 1);
`endif
          end else begin
            count <= count - 1'b1;
          end
        end
        GAP: begin
          if (cnt_zero) begin
            state <= IDLE;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // last bounce cycle settles to the final contact level
  always_comb begin
    contact = 1'b0;
    unique case (state)
      HELD: contact = 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
      BNC_DN: contact = cnt_zero | lfsr[0];
      BNC_UP: contact = ~cnt_zero & lfsr[0];
`endif
      default: contact = 1'b0;
    endcase
  end

  // zero-latency path, like a physical switch
  always_comb begin
    rows = 4'b1111;
    if (contact && !cols[key[1:0]]) begin
      rows[key[3:2]] = 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: directed, table-driven checks of keypad_emulator.
// Covers reset, contact traces, hold boundary, back-to-back and mid reset.
`timescale 1ns/1ps
module tb_keypad_emulator;
  import keypad_pkg::*;

  localparam int B    = 16;
  localparam int G    = 32;
  localparam int HW   = 24;
  localparam int MAXT = 400;
`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int BB = B;
`else
  localparam int BB = 0;
`endif

  logic          clk;
  logic          reset;
  logic [3:0]    cols;
  logic [3:0]    rows;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_key;
  logic [HW-1:0] cmd_hold;
  logic          busy;
  logic          done;

  keypad_emulator #(
    .BOUNCE_CYCLES (B),
    .GAP_CYCLES    (G),
    .HOLD_W        (HW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cols      (cols),
    .rows      (rows),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_key   (cmd_key),
    .cmd_hold  (cmd_hold),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic [3:0] cols;
    logic [3:0] rows;
  } vec_t;

  vec_t       rst_v  [4];
  vec_t       held_v [8];
  logic [3:0] tr     [MAXT];
  logic [3:0] tr0    [MAXT];
  logic [7:0] lfsr_m;
  int         n_cmp;
  int         n_bad;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    cmd_valid = 1'b0;
    reset     = 1'b0;
    lfsr_m    = LFSR_SEED;
    repeat (2) tick;
    reset = 1'b1;
    tick;
  endtask

  task automatic wait_idle(input string name);
    int w;
    w = 0;
    while (busy && w < 1000) begin
      tick;
      w++;
    end
    check(name, busy, 0);
  endtask

  task automatic send(input logic [3:0] k, input logic [HW-1:0] h,
                      output int blen, output int dcnt, output int dpos);
    blen = 0;
    dcnt = 0;
    dpos = -1;
    wait_idle("ready_before_send");
    cmd_key   = k;
    cmd_hold  = h;
    cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
    cmd_key   = ~k;
    cmd_hold  = '1;
    while (busy && blen < MAXT) begin
      tr[blen] = rows;
      if (done) begin
        dcnt++;
        dpos = blen;
      end
      blen++;
      tick;
    end
    check("idle_after_cmd", busy, 0);
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  task automatic check_trace(input string name, input logic [3:0] k,
                             input int h, input logic [3:0] c,
                             input int blen, input int dcnt,
                             input int dpos);
    int         tot;
    logic       con;
    logic [3:0] er;
    tot = 2 * BB + h + G;
    check({name, "_busy_len"}, blen, tot);
    check({name, "_done_cnt"}, dcnt, 1);
    check({name, "_done_pos"}, dpos, tot - 1);
    for (int i = 0; i < blen; i++) begin
      if (i < BB) begin
        con    = (i == BB - 1) ? 1'b1 : lfsr_m[0];
        lfsr_m = lfsr_next(lfsr_m);
      end else if (i < BB + h) begin
        con = 1'b1;
      end else if (i < 2 * BB + h) begin
        con    = (i == 2 * BB + h - 1) ? 1'b0 : lfsr_m[0];
        lfsr_m = lfsr_next(lfsr_m);
      end else begin
        con = 1'b0;
      end
      er = 4'b1111;
      if (con && !c[k[1:0]]) er[k[3:2]] = 1'b0;
      check($sformatf("%s_rows[%0d]", name, i), tr[i], er);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int blen, dcnt, dpos, len0, ndiff, cyc, lastf, first0, w;

    rst_v[0]  = '{4'b1110, 4'b1111};
    rst_v[1]  = '{4'b1101, 4'b1111};
    rst_v[2]  = '{4'b1011, 4'b1111};
    rst_v[3]  = '{4'b0111, 4'b1111};
    held_v[0] = '{4'b1110, 4'b1111};
    held_v[1] = '{4'b1101, 4'b1111};
    held_v[2] = '{4'b1011, 4'b1101};
    held_v[3] = '{4'b0111, 4'b1111};
    held_v[4] = '{4'b0000, 4'b1101};
    held_v[5] = '{4'b1111, 4'b1111};
    held_v[6] = '{4'b1010, 4'b1101};
    held_v[7] = '{4'b0101, 4'b1111};

    n_cmp     = 0;
    n_bad     = 0;
    cols      = 4'b1111;
    cmd_valid = 1'b0;
    cmd_key   = 4'h0;
    cmd_hold  = '0;
    reset     = 1'b0;
    lfsr_m    = LFSR_SEED;

    #5;
    check("rst_rows", rows, 4'b1111);
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    repeat (2) tick;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cols = rst_v[i].cols;
      tick;
      check($sformatf("post_rst_rows[%0d]", i), rows, rst_v[i].rows);
      check($sformatf("post_rst_ready[%0d]", i), cmd_ready, 1);
      check($sformatf("post_rst_busy[%0d]", i), busy, 0);
    end

    // key 6 = row1/col2, scanned on col2
    cols = 4'b1011;
    send(4'h6, 24'd100, blen, dcnt, dpos);
    check_trace("key6", 4'h6, 100, 4'b1011, blen, dcnt, dpos);
`ifdef KEYPAD_EMU_BOUNCE_EN
    check("press_bounce_last_closed", tr[B-1][1], 0);
    check("release_bounce_last_open", tr[2*B+99][1], 1);
`endif

    // cols table applied within one HELD cycle
    cmd_key   = 4'h6;
    cmd_hold  = 24'd100;
    cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
    repeat (BB + 10) tick;
    for (int i = 0; i < 8; i++) begin
      cols = held_v[i].cols;
      #1;
      check($sformatf("held_vec[%0d]", i), rows, held_v[i].rows);
    end
    cols = 4'b1011;
    wait_idle("held_vec_idle");

    // hold 0 must behave as hold 1
    do_reset;
    send(4'h6, 24'd0, blen, dcnt, dpos);
    len0 = blen;
    for (int i = 0; i < MAXT; i++) tr0[i] = tr[i];
    check_trace("hold0", 4'h6, 1, 4'b1011, blen, dcnt, dpos);
    do_reset;
    send(4'h6, 24'd1, blen, dcnt, dpos);
    check_trace("hold1", 4'h6, 1, 4'b1011, blen, dcnt, dpos);
    check("hold0_vs_1_len", len0, blen);
    ndiff = 0;
    for (int i = 0; i < blen && i < len0; i++)
      if (tr0[i] !== tr[i]) ndiff++;
    check("hold0_vs_1_trace", ndiff, 0);

    // back-to-back with cmd_valid held high
    do_reset;
    cols      = 4'b0110;
    cmd_key   = 4'hF;
    cmd_hold  = 24'd5;
    cmd_valid = 1'b1;
    tick;
    check("b2b_first_accept", busy, 1);
    cyc   = 0;
    lastf = -1;
    w     = 0;
    while (!done && w < 500) begin
      if (rows[3] == 1'b0) lastf = cyc;
      cyc++;
      w++;
      tick;
    end
    check("b2b_done_seen", done, 1);
    cmd_key = 4'h0;
    tick;
    cyc++;
    check("b2b_idle_busy", busy, 0);
    check("b2b_idle_ready", cmd_ready, 1);
    check("b2b_idle_rows", rows, 4'b1111);
    tick;
    cyc++;
    check("b2b_second_accept", busy, 1);
    cmd_valid = 1'b0;
    first0 = -1;
    w      = 0;
    while (first0 < 0 && w < 500) begin
      if (rows[0] == 1'b0) first0 = cyc;
      else begin
        cyc++;
        w++;
        tick;
      end
    end
    check("b2b_second_closed", (first0 >= 0), 1);
    check("b2b_open_gap", ((first0 - lastf - 1) >= G), 1);
    wait_idle("b2b_idle_end");

    // asynchronous reset in the middle of HELD
    do_reset;
    cols      = 4'b1011;
    cmd_key   = 4'h6;
    cmd_hold  = 24'd100;
    cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
    repeat (BB + 50) tick;
    check("mid_held_rows", rows, 4'b1101);
    reset  = 1'b0;
    lfsr_m = LFSR_SEED;
    #1;
    check("mid_rst_rows", rows, 4'b1111);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", cmd_ready, 1);
    check("mid_rst_done", done, 0);
    tick;
    check("mid_rst_done_next", done, 0);
    reset = 1'b1;
    tick;
    check("post_mid_rst_done", done, 0);
    cols = 4'b1101;
    send(4'h9, 24'd3, blen, dcnt, dpos);
    check_trace("after_rst", 4'h9, 3, 4'b1101, blen, dcnt, dpos);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
